hdb3_plug_b: RTL and testbench

Second stage of the HDB3 encoder. It sits directly downstream of the V-insertion stage and consumes its 2-bit symbol stream, one symbol per clock. When the number of marks since the previous V is even, it replaces the first 0 of each `000V` group with a B. The output stream feeds the polarity-assignment stage. The symbol encoding is unchanged end to end: 00 = 0, 01 = 1 (mark), 10 = V, 11 = B.

---
 rtl/hdb3_plug_b_if.sv | 16 +
 rtl/hdb3_plug_b.sv | 63 ++++++
 tb/tb_hdb3_plug_b.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hdb3_plug_b_if.sv
// Symbol stream between the V-insertion stage, the B-insertion stage and the polarity stage.
// Symbol encoding: 00 = zero, 01 = mark, 10 = V, 11 = B.
interface hdb3_plug_b_if;
  logic [1:0] i_plug_v_code;
  logic [1:0] o_plug_b_code;

  modport master (
    output i_plug_v_code,
    input  o_plug_b_code
  );

  modport slave (
    input  i_plug_v_code,
    output o_plug_b_code
  );
endinterface

// File: rtl/hdb3_plug_b.sv
// HDB3 encoder stage 2: rewrites the first zero of a 000V group as B when an even
// number of marks has been seen since the previous V. Fixed 4-register delay, no stall.
module hdb3_plug_b #(
  parameter logic P_INIT_PARITY = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  hdb3_plug_b_if.slave bus
);
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_V    = 2'b10;
  localparam logic [1:0] SYM_B    = 2'b11;

  logic [1:0] r_s0;
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_s3;
  logic       r_par;

  logic [1:0] w_in;
  logic       w_is_v;
  logic       w_is_mark;
  logic       w_insert_b;
  logic       w_par_next;
  logic [1:0] w_s3_next;

  assign w_in      = bus.i_plug_v_code;
  assign w_is_v    = (w_in == SYM_V);
  // 01 and 11 both carry a mark; bit 0 distinguishes them from 00 and 10.
  assign w_is_mark = w_in[0];

  // With a V at the input, s2 holds the first zero of its group. A non-zero s2 means
  // the upstream group was malformed, so the slot is left alone rather than overwritten.
  assign w_insert_b = w_is_v && !r_par && (r_s2 == SYM_ZERO);
  assign w_s3_next  = w_insert_b ? SYM_B : r_s2;

  always_comb begin
    w_par_next = r_par;
    if (w_is_v) begin
      w_par_next = 1'b0;
    end else if (w_is_mark) begin
      w_par_next = ~r_par;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s0  <= SYM_ZERO;
      r_s1  <= SYM_ZERO;
      r_s2  <= SYM_ZERO;
      r_s3  <= SYM_ZERO;
      r_par <= P_INIT_PARITY;
    end else begin
      r_s0  <= w_in;
      r_s1  <= r_s0;
      r_s2  <= r_s1;
      r_s3  <= w_s3_next;
      r_par <= w_par_next;
    end
  end

  assign bus.o_plug_b_code = r_s3;
endmodule

// File: tb/tb_hdb3_plug_b.sv
// Directed and random checks of the HDB3 B-insertion stage against hand-computed
// vectors and an independent whole-stream reference.
module tb_hdb3_plug_b;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hdb3_plug_b_if u_if ();

  hdb3_plug_b #(
    .P_INIT_PARITY(1'b0)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (u_if)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0] q_in[$];
  logic [1:0] q_exp[$];

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", tag, got, want);
    end else begin
      $display("ok   %s got=%b", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    u_if.i_plug_v_code = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("flush_after_release", u_if.o_plug_b_code, 2'b00);
  endtask

  // q_exp[t] is the output expected 1ns after the t-th driven edge; it covers
  // three leading flush slots plus every symbol of q_in.
  task automatic run_q(input string tag);
    int n;
    n = q_in.size();
    if (q_exp.size() != n + 3) begin
      $display("FAIL %s vector_length got=%0d want=%0d", tag, q_exp.size(), n + 3);
      n_bad++;
      n_total++;
      return;
    end
    for (int t = 0; t < n + 3; t++) begin
      @(negedge clk);
      u_if.i_plug_v_code = (t < n) ? q_in[t] : 2'b00;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d]", tag, t), u_if.o_plug_b_code, q_exp[t]);
    end
  endtask

  // Reference: whole-stream view. ext = three fill zeros followed by the input; a V at
  // input index k with an even mark count turns ext[k] (if zero) into B.
  task automatic build_ref();
    logic p;
    p = 1'b0;
    q_exp = '{2'b00, 2'b00, 2'b00};
    foreach (q_in[i]) q_exp.push_back(q_in[i]);
    for (int k = 0; k < q_in.size(); k++) begin
      if (q_in[k] == 2'b10) begin
        if (p == 1'b0 && q_exp[k] == 2'b00) q_exp[k] = 2'b11;
        p = 1'b0;
      end else if (q_in[k] == 2'b01 || q_in[k] == 2'b11) begin
        p = ~p;
      end
    end
  endtask

  initial begin
    int zc;
    u_if.i_plug_v_code = 2'b00;
    #1;
    chk("reset_out", u_if.o_plug_b_code, 2'b00);

    // Odd parity at the V: no B.
    do_reset();
    q_in  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    q_exp = '{2'b00, 2'b00, 2'b00,
              2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    run_q("odd_par");

    // Even parity at the V: B inserted three cycles ahead of it.
    do_reset();
    q_in  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    q_exp = '{2'b00, 2'b00, 2'b00,
              2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10};
    run_q("even_par");

    // First V after reset, then a back-to-back group.
    do_reset();
    q_in  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
    q_exp = '{2'b00, 2'b00, 2'b00,
              2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10};
    run_q("b2b");

    // Malformed group, odd parity, then a clean group.
    do_reset();
    q_in  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
    q_exp = '{2'b00, 2'b00, 2'b00,
              2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10};
    run_q("guard_odd");

    // Malformed group with even parity: the mark in the B slot must survive.
    do_reset();
    q_in  = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
    q_exp = '{2'b00, 2'b00, 2'b00,
              2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10};
    run_q("guard_even");

    // V straight after reset lands its B in a flush slot; 11 input counts as a mark.
    do_reset();
    q_in  = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
    q_exp = '{2'b11, 2'b00, 2'b00,
              2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
    run_q("v_at_release");

    // Mid-cycle asynchronous reset with marks buffered and odd parity.
    do_reset();
    q_in  = '{2'b01, 2'b01, 2'b01};
    q_exp = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    run_q("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", u_if.o_plug_b_code, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    q_in  = '{2'b00, 2'b00, 2'b00, 2'b10};
    q_exp = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10};
    run_q("post_rst");

    // Random bits through a V-insertion model, checked against the reference.
    do_reset();
    q_in = {};
    zc = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        q_in.push_back(2'b01);
        zc = 0;
      end else begin
        zc++;
        if (zc == 4) begin
          q_in.push_back(2'b10);
          zc = 0;
        end else begin
          q_in.push_back(2'b00);
        end
      end
    end
    build_ref();
    run_q("rand");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
